// File: rtl/regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2w2r_sb
// Purpose  : Register file with two write ports, two combinational read ports
//            and a per-register busy scoreboard (pending-write tracking).
// Ports    : clk, rst_n (asynchronous, active-low)
//            we0/wa0/wd0, we1/wa1/wd1 : write ports (port 1 wins on collision)
//            ra0/rd0, ra1/rd1         : combinational read ports
//            iss_en/iss_addr          : mark a destination register busy
//            busy0/busy1              : registered busy bit of ra0/ra1
//            busy_cnt                 : registered number of busy registers
// Config   : REGFILE_BYPASS_EN - when defined, a write presented this cycle is
//            forwarded to a read of the same address (port 1 over port 0).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy0,
  output logic              busy1,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int c_depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_depth];
  logic [c_depth-1:0] r_busy;
  logic [ADDR_W:0]    r_busy_cnt;

  logic               w_zero_en;
  logic               w_we0_ok;
  logic               w_we1_ok;
  logic               w_iss_ok;
  logic [c_depth-1:0] w_set;
  logic [c_depth-1:0] w_clr;
  logic [c_depth-1:0] w_busy_nxt;
  logic               w_inc;
  logic               w_dec0;
  logic               w_dec1;

  assign w_zero_en = (ZERO_REG != 0);

  // Accesses aimed at a hard-wired zero register are dropped up front so the
  // storage, scoreboard and bypass paths never see them.
  assign w_we0_ok = we0 && !(w_zero_en && (wa0 == '0));
  assign w_we1_ok = we1 && !(w_zero_en && (wa1 == '0));
  assign w_iss_ok = iss_en && !(w_zero_en && (iss_addr == '0));

  // --------------------------------------------------------------------------
  // Storage: both ports assign in order, so port 1 overrides port 0 when the
  // addresses collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_we0_ok) r_mem[wa0] <= wd0;
      if (w_we1_ok) r_mem[wa1] <= wd1;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard next state: an issue to a register overrides a write to it in
  // the same cycle, because the newly issued producer is still outstanding.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < c_depth; gi++) begin : g_busy
    assign w_set[gi]      = w_iss_ok && (iss_addr == ADDR_W'(gi));
    assign w_clr[gi]      = (w_we0_ok && (wa0 == ADDR_W'(gi))) ||
                            (w_we1_ok && (wa1 == ADDR_W'(gi)));
    assign w_busy_nxt[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
  end

  // Count delta: +1 only for a fresh set, -1 per distinct busy register that
  // is cleared and not re-issued. Port 1 does not count a second clear when
  // both ports hit the same register.
  assign w_inc  = w_iss_ok && !r_busy[iss_addr];
  assign w_dec0 = w_we0_ok && r_busy[wa0] && !(w_iss_ok && (iss_addr == wa0));
  assign w_dec1 = w_we1_ok && r_busy[wa1] && !(w_iss_ok && (iss_addr == wa1)) &&
                  !(w_we0_ok && (wa0 == wa1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_inc)
                                - (ADDR_W+1)'(w_dec0)
                                - (ADDR_W+1)'(w_dec1);
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  always_comb begin
    rd0 = r_mem[ra0];
    rd1 = r_mem[ra1];
    if (w_zero_en && (ra0 == '0)) rd0 = '0;
    if (w_zero_en && (ra1 == '0)) rd1 = '0;
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads return the cleared state.
    if (rst_n) begin
      if (w_we0_ok && (wa0 == ra0)) rd0 = wd0;
      if (w_we1_ok && (wa1 == ra0)) rd0 = wd1;
      if (w_we0_ok && (wa0 == ra1)) rd1 = wd0;
      if (w_we1_ok && (wa1 == ra1)) rd1 = wd1;
    end
`endif
  end

  assign busy0    = r_busy[ra0];
  assign busy1    = r_busy[ra1];
  assign busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2w2r_sb
// Purpose  : Self-checking bench for regfile_2w2r_sb (default parameters).
//            Expectations come from a small behavioural model and are queued
//            when stimulus is driven, then popped and compared against the
//            DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          we0, we1, iss_en;
  logic [AW-1:0] wa0, wa1, ra0, ra1, iss_addr;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd0, rd1;
  logic          busy0, busy1;
  logic [AW:0]   busy_cnt;

  regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .ra0      (ra0),
    .rd0      (rd0),
    .ra1      (ra1),
    .rd1      (rd1),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy0    (busy0),
    .busy1    (busy1),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------- scoreboard
  localparam int K_RD0 = 0, K_RD1 = 1, K_B0 = 2, K_B1 = 3, K_CNT = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic sb_push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RD0:   return rd0;
      K_RD1:   return rd1;
      K_B0:    return {31'd0, busy0};
      K_B1:    return {31'd0, busy1};
      default: return {26'd0, busy_cnt};
    endcase
  endfunction

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.kind), e.exp);
    end
  endtask

  // ------------------------------------------------------------------- model
  logic [31:0] m_mem  [DEPTH];
  logic        m_busy [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_rd(input logic [AW-1:0] ra);
    logic [31:0] v;
    if (ra == '0) return '0;
    v = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && we0 && wa0 == ra) v = wd0;
    if (rst_n && we1 && wa1 == ra) v = wd1;
`endif
    return v;
  endfunction

  // Sequential update of the model for one rising edge; order gives port 1
  // the last word and lets an issue override a same-cycle clear.
  task automatic model_edge();
    if (!rst_n) return;
    if (we0 && wa0 != '0) m_mem[wa0] = wd0;
    if (we1 && wa1 != '0) m_mem[wa1] = wd1;
    if (we0) m_busy[wa0] = 1'b0;
    if (we1) m_busy[wa1] = 1'b0;
    if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
  endtask

  // Inputs are driven 1 ns after a rising edge and stay stable through the
  // next edge, where the model samples them as well.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
  endtask

  task automatic push_state(input string tag);
    sb_push({tag, "_rd0"},  K_RD0, m_rd(ra0));
    sb_push({tag, "_rd1"},  K_RD1, m_rd(ra1));
    sb_push({tag, "_b0"},   K_B0,  {31'd0, m_busy[ra0]});
    sb_push({tag, "_b1"},   K_B1,  {31'd0, m_busy[ra1]});
    sb_push({tag, "_cnt"},  K_CNT, 32'(m_cnt()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b0;
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra0 = '0; ra1 = '0; iss_addr = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    sb_push("rst_cnt", K_CNT, 32'd0);
    sb_push("rst_b0",  K_B0,  32'd0);
    sb_drain();
    rst_n = 1'b1;

    // Post-reset sweep of all addresses on read port 0.
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      ra0 = 5'(a);
      #1;
      sb_push("sweep_rd0", K_RD0, 32'd0);
      sb_push("sweep_b0",  K_B0,  32'd0);
      sb_push("sweep_cnt", K_CNT, 32'd0);
      sb_drain();
    end
    @(posedge clk);
    #1;

    // Same-address double write: port 1 data is kept.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h12345678;
    tick();
    idle();
    ra0 = 5'd5;
    #1;
    sb_push("collide_rd0", K_RD0, 32'h12345678);
    sb_drain();

    // Zero register ignores writes and issues.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    tick();
    idle();
    ra1 = 5'd0;
    #1;
    sb_push("zero_rd1", K_RD1, 32'd0);
    sb_drain();
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    #1;
    sb_push("zero_b1",  K_B1,  32'd0);
    sb_push("zero_cnt", K_CNT, 32'd0);
    sb_drain();

    // Issue r7, then write+reissue r7 (stays busy), then write clears it.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle();
    ra0 = 5'd7;
    #1;
    sb_push("iss7_b0",  K_B0,  32'd1);
    sb_push("iss7_cnt", K_CNT, 32'd1);
    sb_drain();
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h000000A5;
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle();
    #1;
    sb_push("reiss_b0",  K_B0,  32'd1);
    sb_push("reiss_cnt", K_CNT, 32'd1);
    sb_push("reiss_rd0", K_RD0, 32'h000000A5);
    sb_drain();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h00000077;
    #1;
`ifdef REGFILE_BYPASS_EN
    sb_push("clr7_pre_rd0", K_RD0, 32'h00000077);
`else
    sb_push("clr7_pre_rd0", K_RD0, 32'h000000A5);
`endif
    sb_drain();
    tick();
    idle();
    #1;
    sb_push("clr7_b0",  K_B0,  32'd0);
    sb_push("clr7_cnt", K_CNT, 32'd0);
    sb_push("clr7_rd0", K_RD0, 32'h00000077);
    sb_drain();

    // A write to a non-busy register must not decrement the count.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0000BEEF;
    tick();
    idle();
    ra1 = 5'd10;
    #1;
    sb_push("nobusy_cnt", K_CNT, 32'd1);
    sb_push("nobusy_rd1", K_RD1, 32'h0000BEEF);
    sb_drain();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9;
    tick();
    idle();
    #1;
    sb_push("clr9_cnt", K_CNT, 32'd0);
    sb_drain();

    // Same-cycle read of a register being written.
    ra0 = 5'd3;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    sb_push("byp_pre_rd0", K_RD0, 32'h55);
`else
    sb_push("byp_pre_rd0", K_RD0, 32'h0);
`endif
    sb_drain();
    tick();
    idle();
    #1;
    sb_push("byp_post_rd0", K_RD0, 32'h55);
    sb_drain();

    // Issue r1..r3, then asynchronous reset between edges.
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1111;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h2222;
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      tick();
    end
    idle();
    #1;
    sb_push("iss3_cnt", K_CNT, 32'd3);
    sb_drain();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hBAD0;
    iss_en = 1'b1; iss_addr = 5'd4;
    ra0 = 5'd1; ra1 = 5'd2;
    rst_n = 1'b0;
    model_reset();
    #1;
    sb_push("arst_cnt", K_CNT, 32'd0);
    sb_push("arst_b0",  K_B0,  32'd0);
    sb_push("arst_b1",  K_B1,  32'd0);
    sb_push("arst_rd0", K_RD0, 32'd0);
    sb_push("arst_rd1", K_RD1, 32'd0);
    sb_drain();
    ra0 = 5'd3;
    #1;
    sb_push("arst_rd3", K_RD0, 32'd0);
    sb_push("arst_b3",  K_B0,  32'd0);
    sb_drain();
    tick();
    idle();
    #1;
    sb_push("inrst_cnt", K_CNT, 32'd0);
    sb_push("inrst_rd2", K_RD1, 32'd0);
    sb_drain();

    // First edge after release processes a write normally.
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hCAFE;
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    ra0 = 5'd1; ra1 = 5'd6;
    #1;
    sb_push("rel_rd0", K_RD0, 32'hCAFE);
    sb_push("rel_b1",  K_B1,  32'd1);
    sb_push("rel_cnt", K_CNT, 32'd1);
    sb_drain();

    // Randomised traffic on a small address window to force collisions.
    for (int c = 0; c < 300; c++) begin
      we0      = 1'($urandom_range(0, 1));
      we1      = 1'($urandom_range(0, 1));
      iss_en   = 1'($urandom_range(0, 1));
      wa0      = 5'($urandom_range(0, 7));
      wa1      = 5'($urandom_range(0, 7));
      iss_addr = 5'($urandom_range(0, 7));
      wd0      = $urandom;
      wd1      = $urandom;
      ra0      = 5'($urandom_range(0, 7));
      ra1      = (c % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      push_state("rnd");
      sb_drain();
      tick();
    end
    idle();
    #1;
    push_state("final");
    sb_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_2w2r_sb.md
REGFILE_2W2R_SB -- requirements
Module: regfile_2w2r_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; 1 means register 0 reads 0, ignores writes and is never busy.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports we0 / we1  input  1  write enables, write ports 0 and 1.
REQ-007 The block SHALL have ports wa0 / wa1  input  ADDR_W  write addresses.
REQ-008 The block SHALL have ports wd0 / wd1  input  DATA_W  write data.
REQ-009 The block SHALL have ports ra0 / ra1  input  ADDR_W  read addresses.
REQ-010 The block SHALL have ports rd0 / rd1  output  DATA_W  read data for ra0 / ra1.
REQ-011 The block SHALL have port iss_en  input  1  issue strobe; marks iss_addr as pending a write.
REQ-012 The block SHALL have port iss_addr  input  ADDR_W  destination register being issued.
REQ-013 The block SHALL have ports busy0 / busy1  output  1  pending-write flag of ra0 / ra1.
REQ-014 The block SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-015 Writes SHALL commit on the rising clk edge when weN=1; data visible on rdN from the following cycle.
REQ-016 When we0 and we1 target the same address in one cycle, port 1 data SHALL be stored.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be discarded and rd0/rd1 SHALL return 0 for address 0.
REQ-018 Reads SHALL be combinational from ra0/ra1 (zero-cycle latency from address change).
REQ-019 Scoreboard: each register SHALL hold one busy bit, set at clk edge when iss_en=1 for iss_addr.
REQ-020 A committed write (weN=1) SHALL clear the busy bit of waN at the same clk edge.
REQ-021 When iss_en and a write hit the same address in one cycle, the busy bit SHALL end set (new producer wins).
REQ-022 With ZERO_REG=1, iss_en to address 0 SHALL be ignored; busy for address 0 SHALL read 0.
REQ-023 busy0/busy1 SHALL reflect the registered busy bits of ra0/ra1 (no same-cycle forwarding of iss_en or writes).
REQ-024 busy_cnt SHALL be a registered count updated at each edge by +1/-1/-2 net of set and cleared bits; it SHALL never exceed depth nor go below 0.
REQ-025 Writing a register that is not busy SHALL still store data and SHALL NOT decrement busy_cnt.

Reset
REQ-026 rst_n=0 SHALL immediately clear all registers to 0, all busy bits to 0, and busy_cnt to 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any write or issue presented in that cycle; rd0/rd1 read 0, busy0/busy1 read 0.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL process writes and issues normally.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when weN=1 and waN equals raM (and not the zero register), rdM SHALL return wdN in the same cycle, port 1 taking priority over port 0.
REQ-030 Macro REGFILE_BYPASS_EN undefined: rd0/rd1 SHALL return stored contents only; written data appears the cycle after the edge.

Verification
REQ-031 Reset, then ra0=0..31 sweep -> rd0=0 and busy0=0 for all, busy_cnt=0.
REQ-032 we0=1 wa0=5 wd0=0xDEADBEEF, we1=1 wa1=5 wd1=0x12345678, one edge; ra0=5 -> rd0=0x12345678.
REQ-033 we0=1 wa0=0 wd0=0xFFFFFFFF, edge; ra1=0 -> rd1=0; iss_en=1 iss_addr=0, edge -> busy1=0, busy_cnt=0.
REQ-034 iss_en iss_addr=7 edge -> busy_cnt=1, busy0=1 (ra0=7); next cycle we1 wa1=7 wd1=0xA5 plus iss_en iss_addr=7 -> busy stays 1, busy_cnt=1; then we0 wa0=7 -> busy0=0, busy_cnt=0, rd0=0xA5 previously.
REQ-035 Bypass build: ra0=3, we0=1 wa0=3 wd0=0x55 -> rd0=0x55 before the edge; non-bypass build -> rd0 shows old value until after the edge.
REQ-036 Issue registers 1,2,3 over three edges (busy_cnt=3), then drop rst_n between edges -> busy_cnt=0, all busy 0, rd of 1..3 =0 without a clock edge.
